// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    typedef enum logic {OWNER_IF, OWNER_D} arb_owner_t;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 15.
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store data.
// Latency: grant and memory strobe in the request cycle; read data returns READ_LATENCY+1 cycles after grant.
// Backpressure: one access in flight; requests are held until gnt, and no grants are issued while a read is outstanding.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

    arb_state_t             state, state_nxt;
    arb_owner_t             owner;
    arb_owner_t             last;
    logic [LAT_CNT_W-1:0]   lat_cnt;

    logic                   pick_d;
    logic                   pick_if;
    logic                   grant_any;
    logic                   grant_read;

    // Winner selection and memory drive for the grant cycle; grants are only issued from IDLE.
    always_comb begin
        pick_d     = 1'b0;
        pick_if    = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = if_addr;
        mem_wdata  = d_wdata;
        mem_wmask  = 4'b0000;
        grant_any  = 1'b0;
        grant_read = 1'b0;
        state_nxt  = state;

        case (state)
            IDLE: begin
                // Data wins when it is alone, or on contention when fetch was served last.
                pick_d  = rst_n && d_req && (!if_req || (last == OWNER_IF));
                pick_if = rst_n && if_req && !pick_d;

                if_gnt    = pick_if;
                d_gnt     = pick_d;
                grant_any = pick_if || pick_d;
                mem_en    = grant_any;

                if (pick_d) begin
                    mem_addr  = d_addr;
                    mem_we    = d_we;
                    mem_wmask = d_wmask;
                end

                // Writes retire in the grant cycle; only reads wait for returned data.
                grant_read = pick_if || (pick_d && !d_we);
                if (grant_read) begin
                    state_nxt = BUSY;
                end
            end

            BUSY: begin
                if (lat_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, round-robin history, latency countdown and read-data return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            owner     <= OWNER_D;
            last      <= OWNER_IF;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
        end else begin
            state     <= state_nxt;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            if (grant_any) begin
                last <= pick_d ? OWNER_D : OWNER_IF;
            end

            if (grant_read) begin
                owner   <= pick_d ? OWNER_D : OWNER_IF;
                lat_cnt <= LAT_LOAD;
            end

            if (state == BUSY) begin
                if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - 1'b1;
                end else if (owner == OWNER_D) begin
                    d_rdata  <= mem_rdata;
                    d_rvalid <= 1'b1;
                end else begin
                    if_rdata  <= mem_rdata;
                    if_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at READ_LATENCY 1 (instance a) and 3 (instance b).
// Memory model returns address+3 exactly READ_LATENCY cycles after a read strobe.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_mem_arbiter;

    logic clk;
    int   checks;
    int   errors;

    // Instance a: READ_LATENCY = 1
    logic        a_rst_n;
    logic        a_if_req, a_if_gnt, a_if_rvalid;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
    logic [3:0]  a_d_wmask;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wmask;
    logic [31:0] a_pipe;

    // Instance b: READ_LATENCY = 3
    logic        b_rst_n;
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic [3:0]  b_d_wmask;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;
    logic [31:0] b_pipe [3];

    mem_arbiter #(.ADDR_W(32), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_wmask(a_d_wmask), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .READ_LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_wmask(b_d_wmask), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data = address + 3, delayed by the read latency.
    always @(posedge clk) begin
        a_pipe    <= (a_mem_en && !a_mem_we) ? a_mem_addr + 32'd3 : 32'h0;
        b_pipe[0] <= (b_mem_en && !b_mem_we) ? b_mem_addr + 32'd3 : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mem_rdata = a_pipe;
    assign b_mem_rdata = b_pipe[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_if_req = 1'b1; a_if_addr = 32'h200;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100; a_d_wdata = 32'h0; a_d_wmask = 4'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0; b_d_wmask = 4'h0;

        // Reset held three cycles with both requests asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_if_gnt",    a_if_gnt,    0);
            chk("rst_d_gnt",     a_d_gnt,     0);
            chk("rst_mem_en",    a_mem_en,    0);
            chk("rst_if_rvalid", a_if_rvalid, 0);
            chk("rst_d_rvalid",  a_d_rvalid,  0);
            if (i == 2) begin
                chk("rst_if_rdata", a_if_rdata, 0);
                chk("rst_d_rdata",  a_d_rdata,  0);
            end
            next_cycle();
        end

        // Contention straight after reset: data first, then fetch, then data again
        a_rst_n = 1'b1;
        @(negedge clk);                                  // T
        chk("ct_T_d_gnt",    a_d_gnt,    1);
        chk("ct_T_if_gnt",   a_if_gnt,   0);
        chk("ct_T_mem_en",   a_mem_en,   1);
        chk("ct_T_mem_addr", a_mem_addr, 32'h100);
        next_cycle();
        @(negedge clk);                                  // T+1
        chk("ct_T1_mem_en",  a_mem_en,   0);
        chk("ct_T1_if_gnt",  a_if_gnt,   0);
        chk("ct_T1_d_rv",    a_d_rvalid, 0);
        next_cycle();
        @(negedge clk);                                  // T+2
        chk("ct_T2_d_rv",    a_d_rvalid, 1);
        chk("ct_T2_d_rdata", a_d_rdata,  32'h103);
        chk("ct_T2_if_gnt",  a_if_gnt,   1);
        chk("ct_T2_d_gnt",   a_d_gnt,    0);
        chk("ct_T2_mem_addr", a_mem_addr, 32'h200);
        next_cycle();
        @(negedge clk);                                  // T+3
        chk("ct_T3_d_rv",    a_d_rvalid, 0);
        chk("ct_T3_if_rv",   a_if_rvalid, 0);
        next_cycle();
        @(negedge clk);                                  // T+4
        chk("ct_T4_if_rv",    a_if_rvalid, 1);
        chk("ct_T4_if_rdata", a_if_rdata,  32'h203);
        chk("ct_T4_d_gnt",    a_d_gnt,     1);
        chk("ct_T4_if_gnt",   a_if_gnt,    0);
        next_cycle();
        a_if_req = 1'b0; a_d_req = 1'b0;
        @(negedge clk);                                  // T+5
        chk("ct_T5_if_rv", a_if_rvalid, 0);
        next_cycle();
        @(negedge clk);                                  // T+6: non-owner rdata holds
        chk("ct_T6_d_rv",     a_d_rvalid, 1);
        chk("ct_T6_if_rdata", a_if_rdata, 32'h203);
        next_cycle();

        // Single fetch read, latency 1
        a_if_req = 1'b1; a_if_addr = 32'h0000_0010;
        @(negedge clk);
        chk("fr_if_gnt",   a_if_gnt,   1);
        chk("fr_mem_en",   a_mem_en,   1);
        chk("fr_mem_we",   a_mem_we,   0);
        chk("fr_mem_addr", a_mem_addr, 32'h10);
        chk("fr_wmask",    a_mem_wmask, 0);
        next_cycle();
        a_if_req = 1'b0;
        @(negedge clk);
        chk("fr_T1_rv", a_if_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("fr_T2_rv",    a_if_rvalid, 1);
        chk("fr_T2_rdata", a_if_rdata,  32'h13);
        chk("fr_T2_d_rdata", a_d_rdata, 32'h103);
        next_cycle();
        @(negedge clk);
        chk("fr_T3_rv", a_if_rvalid, 0);
        next_cycle();

        // Data write contending with fetch; fetch was served last so data wins
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h2000_0000;
        a_d_wdata = 32'hDEAD_BEEF; a_d_wmask = 4'b0011;
        a_if_req = 1'b1; a_if_addr = 32'h40;
        @(negedge clk);
        chk("wr_d_gnt",     a_d_gnt,     1);
        chk("wr_if_gnt",    a_if_gnt,    0);
        chk("wr_mem_we",    a_mem_we,    1);
        chk("wr_mem_wmask", a_mem_wmask, 4'b0011);
        chk("wr_mem_addr",  a_mem_addr,  32'h2000_0000);
        chk("wr_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        a_d_req = 1'b0; a_d_we = 1'b0;
        @(negedge clk);
        chk("wr_T1_if_gnt", a_if_gnt,    1);
        chk("wr_T1_mem_we", a_mem_we,    0);
        chk("wr_T1_wmask",  a_mem_wmask, 0);
        chk("wr_T1_d_rv",   a_d_rvalid,  0);
        next_cycle();
        a_if_req = 1'b0;
        @(negedge clk);
        chk("wr_T2_d_rv", a_d_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("wr_T3_d_rv",     a_d_rvalid,  0);
        chk("wr_T3_if_rv",    a_if_rvalid, 1);
        chk("wr_T3_if_rdata", a_if_rdata,  32'h43);
        next_cycle();

        // Back-to-back fetch at latency 3: grants every 4 cycles, rvalid coincides
        b_rst_n = 1'b1;
        b_if_req = 1'b1; b_if_addr = 32'h30;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_gnt_%0d", k), b_if_gnt, (k % 4) == 0);
            chk($sformatf("b2b_rv_%0d", k),  b_if_rvalid, (k > 0) && ((k % 4) == 0));
            if (k == 4 || k == 8) chk($sformatf("b2b_rdata_%0d", k), b_if_rdata, 32'h33);
            next_cycle();
        end
        b_if_req = 1'b0;
        repeat (5) next_cycle();

        // Reset during an outstanding data read at latency 3
        b_d_req = 1'b1; b_d_addr = 32'h50;
        @(negedge clk);                                  // T
        chk("rm_T_d_gnt", b_d_gnt, 1);
        next_cycle();
        b_d_req = 1'b0; b_if_req = 1'b1; b_if_addr = 32'h60;
        @(negedge clk);                                  // T+1
        chk("rm_T1_if_gnt", b_if_gnt, 0);
        next_cycle();
        b_rst_n = 1'b0;
        @(negedge clk);                                  // T+2
        chk("rm_T2_if_gnt", b_if_gnt, 0);
        next_cycle();
        b_rst_n = 1'b1;
        @(negedge clk);                                  // T+3
        chk("rm_T3_if_gnt", b_if_gnt,   1);
        chk("rm_T3_d_rv",   b_d_rvalid, 0);
        next_cycle();
        b_if_req = 1'b0;
        @(negedge clk);                                  // T+4
        chk("rm_T4_d_rv",  b_d_rvalid,  0);
        chk("rm_T4_if_rv", b_if_rvalid, 0);
        next_cycle();
        @(negedge clk);                                  // T+5
        chk("rm_T5_d_rv", b_d_rvalid, 0);
        next_cycle();
        @(negedge clk);                                  // T+6
        chk("rm_T6_d_rv", b_d_rvalid, 0);
        next_cycle();
        @(negedge clk);                                  // T+7
        chk("rm_T7_if_rv",    b_if_rvalid, 1);
        chk("rm_T7_if_rdata", b_if_rdata,  32'h63);
        chk("rm_T7_d_rv",     b_d_rvalid,  0);
        chk("rm_T7_d_rdata",  b_d_rdata,   0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
